// File: rtl/frogger_car_lanes_pkg.sv
// Shared definitions for the Frogger road section: coordinate width, grid
// size, default lane rows and the per-lane motion helpers.
package frogger_car_lanes_pkg;

    localparam int unsigned COORD_W   = 6;
    localparam int unsigned GRID_COLS = 40;
    localparam int unsigned GRID_ROWS = 30;

    // Default lane rows, shared with the collision checker and the renderer
    localparam int unsigned LANE_ROW_1 = 24;
    localparam int unsigned LANE_ROW_2 = 23;
    localparam int unsigned LANE_ROW_3 = 22;
    localparam int unsigned LANE_ROW_4 = 21;
    localparam int unsigned LANE_ROW_5 = 20;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Base period scaled down by the speed level, never below one tick
    function automatic logic [7:0] eff_period(input logic [7:0] per,
                                              input logic [1:0] level);
        logic [7:0] shifted;
        shifted = per >> level;
        return (shifted == 8'd0) ? 8'd1 : shifted;
    endfunction

    // One-cell move with wrap at either screen edge
    function automatic logic [COORD_W-1:0] wrap_step(input logic [COORD_W-1:0] x,
                                                     input dir_e              dir,
                                                     input logic [COORD_W-1:0] last);
        if (dir == DIR_LEFT)
            return (x == '0) ? last : x - COORD_W'(1);
        else
            return (x == last) ? '0 : x + COORD_W'(1);
    endfunction

endpackage

// File: rtl/frogger_car_lanes_lane_mover.sv
// One traffic lane: counts base ticks and moves its car one cell whenever
// the level-scaled period has elapsed.
module frogger_lane_mover
    import frogger_car_lanes_pkg::*;
#(
    parameter int unsigned X0     = 0,
    parameter int unsigned PER    = 40,
    parameter logic        DIR    = 1'b0,
    parameter int unsigned GRID_W = 40
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Tick,
    input  logic               i_Restart,
    input  logic [1:0]         i_Level,
    output logic [COORD_W-1:0] o_X,
    output logic               o_Moved
);

    localparam dir_e               MOVE_DIR = dir_e'(DIR);
    localparam logic [COORD_W-1:0] X_INIT   = COORD_W'(X0);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID_W - 1);
    localparam logic [7:0]         PER_8    = 8'(PER);

    logic [7:0] r_Cnt;
    logic [7:0] w_Eff;
    logic       w_Due;

    // Level is used in the tick cycle itself; >= lets a level raise that
    // overshoots the new period fire on the very next tick.
    assign w_Eff = eff_period(PER_8, i_Level);
    assign w_Due = (r_Cnt >= (w_Eff - 8'd1));

    // Lane counter, car position and moved flag; restart beats any tick
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_X     <= X_INIT;
            r_Cnt   <= '0;
            o_Moved <= 1'b0;
        end else if (i_Restart) begin
            o_X     <= X_INIT;
            r_Cnt   <= '0;
            o_Moved <= 1'b0;
        end else if (i_Tick) begin
            if (w_Due) begin
                o_X     <= wrap_step(o_X, MOVE_DIR, X_LAST);
                r_Cnt   <= '0;
                o_Moved <= 1'b1;
            end else begin
                r_Cnt   <= r_Cnt + 8'd1;
                o_Moved <= 1'b0;
            end
        end else begin
            o_Moved <= 1'b0;
        end
    end

endmodule

// File: rtl/frogger_car_lanes.sv
// Traffic generator for the road section: base-tick prescaler, five lane
// movers and the constant lane rows.
module frogger_car_lanes
    import frogger_car_lanes_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 250000,
    parameter int unsigned GRID_W     = GRID_COLS,
    parameter int unsigned LANE_Y_1   = LANE_ROW_1,
    parameter int unsigned LANE_Y_2   = LANE_ROW_2,
    parameter int unsigned LANE_Y_3   = LANE_ROW_3,
    parameter int unsigned LANE_Y_4   = LANE_ROW_4,
    parameter int unsigned LANE_Y_5   = LANE_ROW_5,
    parameter int unsigned LANE_X0_1  = 0,
    parameter int unsigned LANE_X0_2  = 39,
    parameter int unsigned LANE_X0_3  = 10,
    parameter int unsigned LANE_X0_4  = 30,
    parameter int unsigned LANE_X0_5  = 20,
    parameter int unsigned LANE_PER_1 = 40,
    parameter int unsigned LANE_PER_2 = 30,
    parameter int unsigned LANE_PER_3 = 20,
    parameter int unsigned LANE_PER_4 = 25,
    parameter int unsigned LANE_PER_5 = 15,
    parameter logic [4:0]  LANE_DIR   = 5'b01010
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Restart,
    input  logic       i_Freeze,
    input  logic [1:0] i_Level,
    output logic [5:0] o_Car_X_1,
    output logic [5:0] o_Car_X_2,
    output logic [5:0] o_Car_X_3,
    output logic [5:0] o_Car_X_4,
    output logic [5:0] o_Car_X_5,
    output logic [5:0] o_Car_Y_1,
    output logic [5:0] o_Car_Y_2,
    output logic [5:0] o_Car_Y_3,
    output logic [5:0] o_Car_Y_4,
    output logic [5:0] o_Car_Y_5,
    output logic       o_Step
);

    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_Div;
    logic             w_Tick;
    logic [4:0]       w_Moved;

    // Freeze suppresses the tick in the same cycle it is seen
    assign w_Tick = (r_Div == DIV_LAST) && !i_Freeze;

    // Base-tick prescaler; holds while frozen, cleared by restart
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Div <= '0;
        end else if (i_Restart) begin
            r_Div <= '0;
        end else if (!i_Freeze) begin
            r_Div <= (r_Div == DIV_LAST) ? '0 : r_Div + DIV_W'(1);
        end
    end

    frogger_lane_mover #(.X0(LANE_X0_1), .PER(LANE_PER_1), .DIR(LANE_DIR[0]), .GRID_W(GRID_W)) u_lane_1 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Tick(w_Tick), .i_Restart(i_Restart),
        .i_Level(i_Level), .o_X(o_Car_X_1), .o_Moved(w_Moved[0])
    );
    frogger_lane_mover #(.X0(LANE_X0_2), .PER(LANE_PER_2), .DIR(LANE_DIR[1]), .GRID_W(GRID_W)) u_lane_2 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Tick(w_Tick), .i_Restart(i_Restart),
        .i_Level(i_Level), .o_X(o_Car_X_2), .o_Moved(w_Moved[1])
    );
    frogger_lane_mover #(.X0(LANE_X0_3), .PER(LANE_PER_3), .DIR(LANE_DIR[2]), .GRID_W(GRID_W)) u_lane_3 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Tick(w_Tick), .i_Restart(i_Restart),
        .i_Level(i_Level), .o_X(o_Car_X_3), .o_Moved(w_Moved[2])
    );
    frogger_lane_mover #(.X0(LANE_X0_4), .PER(LANE_PER_4), .DIR(LANE_DIR[3]), .GRID_W(GRID_W)) u_lane_4 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Tick(w_Tick), .i_Restart(i_Restart),
        .i_Level(i_Level), .o_X(o_Car_X_4), .o_Moved(w_Moved[3])
    );
    frogger_lane_mover #(.X0(LANE_X0_5), .PER(LANE_PER_5), .DIR(LANE_DIR[4]), .GRID_W(GRID_W)) u_lane_5 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Tick(w_Tick), .i_Restart(i_Restart),
        .i_Level(i_Level), .o_X(o_Car_X_5), .o_Moved(w_Moved[4])
    );

    // Moved flags are registered, so the OR is a clean one-cycle pulse
    assign o_Step = |w_Moved;

    assign o_Car_Y_1 = 6'(LANE_Y_1);
    assign o_Car_Y_2 = 6'(LANE_Y_2);
    assign o_Car_Y_3 = 6'(LANE_Y_3);
    assign o_Car_Y_4 = 6'(LANE_Y_4);
    assign o_Car_Y_5 = 6'(LANE_Y_5);

endmodule
